// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the phase reset sequencer: FSM states,
// phase-selection result and the enabled-phase search function.
package phase_seq_pkg;

    typedef enum logic [1:0] {STARTUP, RUN, HOLD, HALTED} state_t;

    localparam int MAX_PHASES = 32;
    localparam int SEL_W      = 5;

    typedef struct packed {
        logic             valid;
        logic             wrapped;
        logic [SEL_W-1:0] idx;
    } sel_t;

    function automatic int phase_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // wrap_flag=1: first enabled phase strictly above cur, else wrap to the lowest.
    // wrap_flag=0: lowest enabled phase (initial selection).
    function automatic sel_t next_enabled(input logic [MAX_PHASES-1:0] mask,
                                          input int cur, input logic wrap_flag);
        sel_t res;
        res = '0;
        for (int i = 0; i < MAX_PHASES; i++) begin
            if (!res.valid && mask[i] && (!wrap_flag || i > cur)) begin
                res.valid = 1'b1;
                res.idx   = SEL_W'(i);
            end
        end
        if (wrap_flag && !res.valid) begin
            for (int i = 0; i < MAX_PHASES; i++) begin
                if (!res.valid && mask[i]) begin
                    res.valid   = 1'b1;
                    res.wrapped = 1'b1;
                    res.idx     = SEL_W'(i);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/phase_reset_sequencer_timer.sv
// Loadable down-counter shared by the STARTUP and HOLD intervals.
module seq_cycle_timer #(
    parameter int W    = 2,
    parameter int INIT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= W'(INIT);
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    // High on the edge whose decrement brings the count to zero.
    assign zero = dec && (count == W'(1));

endmodule

// File: rtl/phase_reset_sequencer.sv
// Releases one compute unit at a time from reset, re-asserting all resets for a
// hold interval between phases, until halt, the iteration limit or a config error.
module phase_reset_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES     = 2,
    parameter int STARTUP_CYCLES = 2,
    parameter int HOLD_CYCLES    = 4,
    parameter int MAX_ITER       = 0,
    parameter int ITER_W         = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PHASES-1:0]                phase_mask,
    input  logic [NUM_PHASES-1:0]                phase_done,
    input  logic                                 halt,
    output logic [NUM_PHASES-1:0]                unit_reset,
    output logic [phase_idx_w(NUM_PHASES)-1:0]   cur_phase,
    output logic [ITER_W-1:0]                    iter_count,
    output logic                                 running,
    output logic                                 done,
    output logic                                 err
);

    localparam int PW   = phase_idx_w(NUM_PHASES);
    localparam int TMAX = (STARTUP_CYCLES > HOLD_CYCLES) ? STARTUP_CYCLES : HOLD_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t                state, state_next;
    logic [NUM_PHASES-1:0] unit_reset_next;
    logic [PW-1:0]         cur_phase_next;
    logic [ITER_W-1:0]     iter_next, iter_inc;
    logic                  running_next, done_next, err_next;
    logic                  tmr_load, tmr_dec, tmr_zero;
    sel_t                  sel;

    seq_cycle_timer #(
        .W    (TW),
        .INIT (STARTUP_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (TW'(HOLD_CYCLES)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= STARTUP;
            unit_reset <= '1;
            cur_phase  <= '0;
            iter_count <= '0;
            running    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            unit_reset <= unit_reset_next;
            cur_phase  <= cur_phase_next;
            iter_count <= iter_next;
            running    <= running_next;
            done       <= done_next;
            err        <= err_next;
        end
    end

    always_comb begin
        state_next      = state;
        unit_reset_next = unit_reset;
        cur_phase_next  = cur_phase;
        iter_next       = iter_count;
        running_next    = running;
        done_next       = done;
        err_next        = err;
        tmr_load        = 1'b0;
        tmr_dec         = 1'b0;
        iter_inc        = (iter_count == '1) ? iter_count : iter_count + ITER_W'(1);
        sel             = next_enabled(MAX_PHASES'(phase_mask), int'(cur_phase), state == HOLD);

        unique case (state)
            STARTUP, HOLD: begin
                tmr_dec = 1'b1;
                if (halt) begin
                    state_next      = HALTED;
                    unit_reset_next = '1;
                    running_next    = 1'b0;
                    done_next       = 1'b1;
                end else if (tmr_zero) begin
                    if (!sel.valid) begin
                        state_next      = HALTED;
                        unit_reset_next = '1;
                        running_next    = 1'b0;
                        done_next       = 1'b1;
                        err_next        = 1'b1;
                    end else if (sel.wrapped && MAX_ITER != 0 && iter_inc == ITER_W'(MAX_ITER)) begin
                        // Final pass complete: stop instead of releasing again.
                        iter_next       = iter_inc;
                        state_next      = HALTED;
                        unit_reset_next = '1;
                        running_next    = 1'b0;
                        done_next       = 1'b1;
                    end else begin
                        if (sel.wrapped) begin
                            iter_next = iter_inc;
                        end
                        state_next      = RUN;
                        unit_reset_next = ~(NUM_PHASES'(1) << sel.idx);
                        cur_phase_next  = PW'(sel.idx);
                        running_next    = 1'b1;
                    end
                end
            end
            RUN: begin
                if (halt) begin
                    state_next      = HALTED;
                    unit_reset_next = '1;
                    running_next    = 1'b0;
                    done_next       = 1'b1;
                end else if (phase_done[cur_phase]) begin
                    state_next      = HOLD;
                    unit_reset_next = '1;
                    running_next    = 1'b0;
                    tmr_load        = 1'b1;
                end
            end
            HALTED: begin
                unit_reset_next = '1;
                running_next    = 1'b0;
                done_next       = 1'b1;
            end
            default: begin
                state_next = HALTED;
            end
        endcase
    end

endmodule

// File: tb/tb_phase_reset_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed expectations keyed by clock
// edge; monitors pop and compare at the falling edge. Two DUT configurations.
module tb_phase_reset_sequencer;

    typedef struct {
        int          at;
        string       name;
        logic [2:0]  ur;
        logic [1:0]  cp;
        logic [15:0] it;
        logic        run;
        logic        dn;
        logic        er;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    // DUT A: defaults
    logic        reset_a = 1'b1;
    logic [1:0]  mask_a = 2'b11, pdone_a = 2'b00;
    logic        halt_a = 1'b0;
    logic [1:0]  ur_a;
    logic [0:0]  cp_a;
    logic [15:0] it_a;
    logic        run_a, dn_a, er_a;

    phase_reset_sequencer dut_a (
        .clk(clk), .reset(reset_a), .phase_mask(mask_a), .phase_done(pdone_a),
        .halt(halt_a), .unit_reset(ur_a), .cur_phase(cp_a), .iter_count(it_a),
        .running(run_a), .done(dn_a), .err(er_a)
    );

    // DUT B: three phases, two full passes
    logic        reset_b = 1'b1;
    logic [2:0]  mask_b = 3'b101, pdone_b = 3'b000;
    logic        halt_b = 1'b0;
    logic [2:0]  ur_b;
    logic [1:0]  cp_b;
    logic [15:0] it_b;
    logic        run_b, dn_b, er_b;

    phase_reset_sequencer #(.NUM_PHASES(3), .MAX_ITER(2)) dut_b (
        .clk(clk), .reset(reset_b), .phase_mask(mask_b), .phase_done(pdone_b),
        .halt(halt_b), .unit_reset(ur_b), .cur_phase(cp_b), .iter_count(it_b),
        .running(run_b), .done(dn_b), .err(er_b)
    );

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_a(input int at, input string nm, input logic [1:0] ur, input logic cp,
                         input int it, input logic run, input logic dn, input logic er);
        exp_t e;
        e.at = at; e.name = nm; e.ur = {1'b0, ur}; e.cp = {1'b0, cp}; e.it = 16'(it);
        e.run = run; e.dn = dn; e.er = er;
        qa.push_back(e);
    endtask

    task automatic exp_b(input int at, input string nm, input logic [2:0] ur, input logic [1:0] cp,
                         input int it, input logic run, input logic dn, input logic er);
        exp_t e;
        e.at = at; e.name = nm; e.ur = ur; e.cp = cp; e.it = 16'(it);
        e.run = run; e.dn = dn; e.er = er;
        qb.push_back(e);
    endtask

    task automatic compare(input exp_t e, input logic [2:0] ur, input logic [1:0] cp,
                           input logic [15:0] it, input logic run, input logic dn, input logic er);
        checks++;
        if ({ur, cp, it, run, dn, er} !== {e.ur, e.cp, e.it, e.run, e.dn, e.er}) begin
            errors++;
            $display("FAIL %s @%0d: got ur=%b cp=%0d it=%0d run=%b done=%b err=%b, expected ur=%b cp=%0d it=%0d run=%b done=%b err=%b",
                     e.name, cyc, ur, cp, it, run, dn, er, e.ur, e.cp, e.it, e.run, e.dn, e.er);
        end
    endtask

    always @(negedge clk) begin
        while (qa.size() != 0 && qa[0].at <= cyc) begin
            compare(qa.pop_front(), {1'b0, ur_a}, {1'b0, cp_a}, it_a, run_a, dn_a, er_a);
        end
        if (cyc >= 1) begin
            checks++;
            if (!($countones(~ur_a) <= 1 && (run_a || ur_a == 2'b11))) begin
                errors++;
                $display("FAIL inv_a @%0d: got ur=%b run=%b, expected <=1 low bit and all ones outside RUN", cyc, ur_a, run_a);
            end
        end
    end

    always @(negedge clk) begin
        while (qb.size() != 0 && qb[0].at <= cyc) begin
            compare(qb.pop_front(), ur_b, cp_b, it_b, run_b, dn_b, er_b);
        end
        if (cyc >= 1) begin
            checks++;
            if (!($countones(~ur_b) <= 1 && (run_b || ur_b == 3'b111) && ur_b[1] == 1'b1)) begin
                errors++;
                $display("FAIL inv_b @%0d: got ur=%b run=%b, expected <=1 low bit, all ones outside RUN, phase 1 held", cyc, ur_b, run_b);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of stimulus, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            begin : flow_a
                goto(3);
                exp_a(3,  "a_reset",        2'b11, 1'b0, 0, 0, 0, 0);
                reset_a = 1'b0;
                exp_a(4,  "a_startup",      2'b11, 1'b0, 0, 0, 0, 0);
                exp_a(5,  "a_release0",     2'b10, 1'b0, 0, 1, 0, 0);
                exp_a(10, "a_run0",         2'b10, 1'b0, 0, 1, 0, 0);
                exp_a(11, "a_hold0",        2'b11, 1'b0, 0, 0, 0, 0);
                exp_a(14, "a_hold0_end",    2'b11, 1'b0, 0, 0, 0, 0);
                exp_a(15, "a_release1",     2'b01, 1'b1, 0, 1, 0, 0);
                exp_a(17, "a_hold1",        2'b11, 1'b1, 0, 0, 0, 0);
                exp_a(21, "a_wrap0",        2'b10, 1'b0, 1, 1, 0, 0);
                exp_a(25, "a_ignore_done1", 2'b10, 1'b0, 1, 1, 0, 0);
                exp_a(27, "a_hold0b",       2'b11, 1'b0, 1, 0, 0, 0);
                exp_a(30, "a_hold0b_end",   2'b11, 1'b0, 1, 0, 0, 0);
                exp_a(31, "a_mask01_wrap",  2'b10, 1'b0, 2, 1, 0, 0);
                exp_a(33, "a_halt_prio",    2'b11, 1'b0, 2, 0, 1, 0);
                exp_a(38, "a_halted_stay",  2'b11, 1'b0, 2, 0, 1, 0);
                goto(10); pdone_a = 2'b01;
                goto(11); pdone_a = 2'b00;
                goto(16); pdone_a = 2'b10;
                goto(17); pdone_a = 2'b00;
                goto(22); pdone_a = 2'b10;
                goto(25); pdone_a = 2'b00;
                goto(26); pdone_a = 2'b01;
                goto(27); pdone_a = 2'b00;
                goto(28); mask_a = 2'b01;
                goto(32); pdone_a = 2'b01; halt_a = 1'b1;
                goto(33); pdone_a = 2'b00; halt_a = 1'b0;
                goto(34); pdone_a = 2'b11; mask_a = 2'b11;
                goto(36); pdone_a = 2'b00;
                // Reset mid-RUN of phase 1
                exp_a(39, "a_reset2",       2'b11, 1'b0, 0, 0, 0, 0);
                exp_a(41, "a_rel0_r2",      2'b10, 1'b0, 0, 1, 0, 0);
                exp_a(46, "a_rel1_r2",      2'b01, 1'b1, 0, 1, 0, 0);
                exp_a(48, "a_reset_midrun", 2'b11, 1'b0, 0, 0, 0, 0);
                exp_a(49, "a_restart_cnt",  2'b11, 1'b0, 0, 0, 0, 0);
                exp_a(50, "a_restart_rel",  2'b10, 1'b0, 0, 1, 0, 0);
                goto(38); reset_a = 1'b1;
                goto(39); reset_a = 1'b0;
                goto(41); pdone_a = 2'b01;
                goto(42); pdone_a = 2'b00;
                goto(47); reset_a = 1'b1;
                goto(48); reset_a = 1'b0;
                // Empty mask at the end of STARTUP
                exp_a(51, "a_reset3",       2'b11, 1'b0, 0, 0, 0, 0);
                exp_a(52, "a_startup3",     2'b11, 1'b0, 0, 0, 0, 0);
                exp_a(53, "a_no_phase_err", 2'b11, 1'b0, 0, 0, 1, 1);
                exp_a(56, "a_err_sticky",   2'b11, 1'b0, 0, 0, 1, 1);
                goto(50); reset_a = 1'b1; mask_a = 2'b00;
                goto(51); reset_a = 1'b0;
                goto(54); pdone_a = 2'b11;
                goto(56); pdone_a = 2'b00;
            end
            begin : flow_b
                goto(2);
                exp_b(2,  "b_reset",      3'b111, 2'd0, 0, 0, 0, 0);
                reset_b = 1'b0;
                exp_b(4,  "b_release0",   3'b110, 2'd0, 0, 1, 0, 0);
                exp_b(6,  "b_hold0",      3'b111, 2'd0, 0, 0, 0, 0);
                exp_b(9,  "b_hold0_end",  3'b111, 2'd0, 0, 0, 0, 0);
                exp_b(10, "b_release2",   3'b011, 2'd2, 0, 1, 0, 0);
                exp_b(16, "b_wrap0",      3'b110, 2'd0, 1, 1, 0, 0);
                exp_b(22, "b_release2b",  3'b011, 2'd2, 1, 1, 0, 0);
                exp_b(27, "b_hold_last",  3'b111, 2'd2, 1, 0, 0, 0);
                exp_b(28, "b_iter_limit", 3'b111, 2'd2, 2, 0, 1, 0);
                exp_b(34, "b_halted",     3'b111, 2'd2, 2, 0, 1, 0);
                goto(5);  pdone_b = 3'b001;
                goto(6);  pdone_b = 3'b000;
                goto(11); pdone_b = 3'b100;
                goto(12); pdone_b = 3'b000;
                goto(17); pdone_b = 3'b001;
                goto(18); pdone_b = 3'b000;
                goto(23); pdone_b = 3'b100;
                goto(24); pdone_b = 3'b000;
                goto(30); pdone_b = 3'b111; mask_b = 3'b111;
                goto(32); pdone_b = 3'b000;
            end
        join
        goto(60);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d/%0d unchecked entries, expected 0/0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
